matmul_core_scheduler: RTL and testbench

Job scheduler for the four processing cores behind the top-level result registers r1..r4. On start_process it walks every output element (row, col) of a dim x dim result matrix in row-major order and hands each element to the lowest-index idle core via a start/done handshake. It drains all in-flight jobs, then pulses end_process. It sits between the top-level start/end interface and the core array.

---
 rtl/matmul_core_scheduler_if.sv | 26 ++
 rtl/matmul_core_scheduler.sv | 130 +++++++++++++
 tb/tb_matmul_core_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_core_scheduler_if.sv
// rtl/matmul_core_scheduler_if.sv - start/end and core-array signals of the matmul job scheduler
interface matmul_core_scheduler_if #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = 8,
    parameter int CNT_W   = 16
);
    logic                       start_process;
    logic [IDX_W-1:0]           dim;
    logic [N_CORES-1:0]         core_done;
    logic [N_CORES-1:0]         core_start;
    logic [N_CORES*IDX_W-1:0]   core_row;
    logic [N_CORES*IDX_W-1:0]   core_col;
    logic                       busy;
    logic                       end_process;
    logic [CNT_W-1:0]           jobs_done;

    modport master (
        output start_process, dim, core_done,
        input  core_start, core_row, core_col, busy, end_process, jobs_done
    );

    modport slave (
        input  start_process, dim, core_done,
        output core_start, core_row, core_col, busy, end_process, jobs_done
    );
endinterface

// File: rtl/matmul_core_scheduler.sv
// rtl/matmul_core_scheduler.sv - row-major job scheduler handing matrix elements to four cores
// Defining SCHED_PERF_CNT_EN adds the saturating cycle_count output.
module matmul_core_scheduler #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0] cycle_count,
`endif
    matmul_core_scheduler_if.slave bus
);
    localparam int SEL_W = $clog2(N_CORES);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t             state;
    logic [N_CORES-1:0] core_busy;
    logic [N_CORES-1:0] done_hits;
    logic [N_CORES-1:0] busy_next;
    logic [IDX_W-1:0]   dim_q;
    logic [IDX_W-1:0]   row_ptr;
    logic [IDX_W-1:0]   col_ptr;
    logic               issue_ok;
    logic [SEL_W-1:0]   issue_idx;
    logic [CNT_W-1:0]   done_cnt;
    logic               col_last;
    logic               last_job;

    // Dispatch looks only at flags from before this edge, so a core freed now waits a cycle.
    always_comb begin
        issue_ok  = 1'b0;
        issue_idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (!core_busy[i]) begin
                issue_ok  = 1'b1;
                issue_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        done_hits = bus.core_done & core_busy;
        busy_next = core_busy & ~done_hits;
        done_cnt  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            done_cnt = done_cnt + CNT_W'(done_hits[i]);
        end
        col_last = (col_ptr == dim_q - IDX_W'(1));
        last_job = col_last && (row_ptr == dim_q - IDX_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            core_busy       <= '0;
            dim_q           <= '0;
            row_ptr         <= '0;
            col_ptr         <= '0;
            bus.core_start  <= '0;
            bus.core_row    <= '0;
            bus.core_col    <= '0;
            bus.busy        <= 1'b0;
            bus.end_process <= 1'b0;
            bus.jobs_done   <= '0;
        end else begin
            bus.core_start  <= '0;
            bus.end_process <= 1'b0;
            if (state != IDLE) begin
                core_busy     <= busy_next;
                bus.jobs_done <= bus.jobs_done + done_cnt;
            end
            case (state)
                IDLE: begin
                    if (bus.start_process) begin
                        dim_q         <= bus.dim;
                        row_ptr       <= '0;
                        col_ptr       <= '0;
                        bus.jobs_done <= '0;
                        bus.busy      <= 1'b1;
                        state         <= (bus.dim == '0) ? DONE : DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (issue_ok) begin
                        bus.core_start[issue_idx]                       <= 1'b1;
                        bus.core_row[int'(issue_idx)*IDX_W +: IDX_W]    <= row_ptr;
                        bus.core_col[int'(issue_idx)*IDX_W +: IDX_W]    <= col_ptr;
                        core_busy[issue_idx]                            <= 1'b1;
                        // Pointers stay on the last element so they never pass dim-1.
                        if (last_job) begin
                            state <= DRAIN;
                        end else if (col_last) begin
                            col_ptr <= '0;
                            row_ptr <= row_ptr + IDX_W'(1);
                        end else begin
                            col_ptr <= col_ptr + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (busy_next == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.end_process <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (state == IDLE && bus.start_process) begin
            cycle_count <= '0;
        end else if (bus.busy && cycle_count != '1) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_core_scheduler.sv
// tb/tb_matmul_core_scheduler.sv - randomized self-checking bench for matmul_core_scheduler
module tb_matmul_core_scheduler;
    localparam int NC = 4;
    localparam int IW = 8;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_core_scheduler_if #(.N_CORES(NC), .IDX_W(IW), .CNT_W(CW)) bus ();
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] cycle_count;
`endif

    matmul_core_scheduler #(.N_CORES(NC), .IDX_W(IW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef SCHED_PERF_CNT_EN
        .cycle_count (cycle_count),
`endif
        .bus         (bus)
    );

    typedef struct {
        int off;
        int core;
        int row;
        int col;
    } iss_t;

    int total = 0;
    int bad   = 0;

    bit          m_active;
    bit          m_finish;
    int          m_dim;
    int          m_total;
    int          m_issued;
    int          m_jobs;
    logic [3:0]  m_cbusy;
    logic [3:0]  e_start;
    logic [31:0] e_row;
    logic [31:0] e_col;
    logic        e_busy;
    logic        e_end;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] e_cc;
`endif
    int          edge_no;
    int          acc_edge;
    int          end_off;
    iss_t        log_q[$];

    int timer[NC];
    int lat_tab[NC];
    bit lat_rand;
    bit spur_done;
    bit spur_start;
    bit hold_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_finish = 0;
        m_dim    = 0;
        m_total  = 0;
        m_issued = 0;
        m_jobs   = 0;
        m_cbusy  = '0;
        e_start  = '0;
        e_row    = '0;
        e_col    = '0;
        e_busy   = 1'b0;
        e_end    = 1'b0;
`ifdef SCHED_PERF_CNT_EN
        e_cc     = '0;
`endif
        for (int i = 0; i < NC; i++) timer[i] = 0;
    endtask

    // Job j of a run is element (j / dim, j % dim); each edge hands the next job to the lowest idle core.
    task automatic model_edge(input logic st, input logic [7:0] d, input logic [3:0] done);
        logic [3:0] pre;
        logic [3:0] freed;
        bit         issued_now;
        e_start = '0;
        e_end   = 1'b0;
`ifdef SCHED_PERF_CNT_EN
        if (e_busy && e_cc != 32'hFFFF_FFFF) e_cc = e_cc + 1;
`endif
        if (!m_active) begin
            if (st) begin
                m_active = 1;
                m_dim    = int'(d);
                m_total  = m_dim * m_dim;
                m_issued = 0;
                m_jobs   = 0;
                m_finish = (m_dim == 0);
                e_busy   = 1'b1;
`ifdef SCHED_PERF_CNT_EN
                e_cc     = '0;
`endif
                acc_edge = edge_no;
                end_off  = -1;
                log_q.delete();
            end
        end else if (m_finish) begin
            e_end    = 1'b1;
            e_busy   = 1'b0;
            m_active = 0;
            m_finish = 0;
            end_off  = edge_no - acc_edge;
        end else begin
            pre     = m_cbusy;
            freed   = done & m_cbusy;
            m_jobs  = m_jobs + $countones(freed);
            m_cbusy = m_cbusy & ~freed;
            if (m_issued < m_total) begin
                issued_now = 0;
                for (int i = 0; i < NC; i++) begin
                    if (!pre[i] && !issued_now) begin
                        issued_now           = 1;
                        e_start[i]           = 1'b1;
                        e_row[i*IW +: IW]    = 8'(m_issued / m_dim);
                        e_col[i*IW +: IW]    = 8'(m_issued % m_dim);
                        m_cbusy[i]           = 1'b1;
                        log_q.push_back('{edge_no - acc_edge, i, m_issued / m_dim, m_issued % m_dim});
                        m_issued++;
                    end
                end
            end else if (m_cbusy == '0) begin
                m_finish = 1;
            end
        end
    endtask

    task automatic compare();
        chk("core_start", 32'(bus.core_start), 32'(e_start));
        chk("core_row", bus.core_row, e_row);
        chk("core_col", bus.core_col, e_col);
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("end_process", 32'(bus.end_process), 32'(e_end));
        chk("jobs_done", 32'(bus.jobs_done), 32'(m_jobs % 65536));
`ifdef SCHED_PERF_CNT_EN
        chk("cycle_count", cycle_count, e_cc);
`endif
    endtask

    task automatic step();
        logic [3:0] dn;
        @(posedge clk);
        edge_no++;
        if (!rst_n) model_reset();
        else model_edge(bus.start_process, bus.dim, bus.core_done);
        #1;
        compare();
        dn = '0;
        for (int i = 0; i < NC; i++) begin
            if (timer[i] > 0) begin
                timer[i]--;
                if (timer[i] == 0) dn[i] = 1'b1;
            end
            if (bus.core_start[i]) timer[i] = lat_rand ? int'($urandom_range(1, 5)) : lat_tab[i];
        end
        if (spur_done && !m_cbusy[2] && timer[2] == 0 && $urandom_range(0, 2) == 0) dn[2] = 1'b1;
        bus.core_done = rst_n ? dn : 4'b0;
        if (spur_start) bus.start_process = (m_active && !m_finish) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic run(input int d, input int budget);
        int n;
        bus.dim           = 8'(d);
        bus.start_process = 1'b1;
        step();
        bus.dim = 8'($urandom_range(0, 255));
        if (!hold_start) bus.start_process = 1'b0;
        n = 0;
        while (!e_end && !bus.end_process && n < budget) begin
            step();
            n++;
        end
        chk("run_end_seen", 32'(bus.end_process), 32'd1);
    endtask

    initial begin
        int c0;
        bus.start_process = 1'b0;
        bus.dim           = '0;
        bus.core_done     = '0;
        lat_rand   = 0;
        spur_done  = 0;
        spur_start = 0;
        hold_start = 0;
        edge_no    = 0;
        acc_edge   = 0;
        end_off    = -1;
        for (int i = 0; i < NC; i++) lat_tab[i] = 3;
        model_reset();
        chk("reset_busy_lit", 32'(bus.busy), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        run(2, 100);
        chk("d2_issue_cnt", log_q.size(), 4);
        for (int j = 0; j < 4 && j < log_q.size(); j++) begin
            chk("d2_issue_off", log_q[j].off, j + 1);
            chk("d2_issue_core", log_q[j].core, j);
            chk("d2_issue_row", log_q[j].row, j / 2);
            chk("d2_issue_col", log_q[j].col, j % 2);
        end
        chk("d2_end_off", end_off, 9);
        chk("d2_jobs_lit", 32'(bus.jobs_done), 32'd4);
        step();

        lat_tab = '{1, 20, 20, 20};
        run(3, 200);
        c0 = 0;
        for (int j = 0; j < log_q.size(); j++) begin
            if (log_q[j].core == 0) c0++;
            chk("d3_row_major", log_q[j].row * 3 + log_q[j].col, j);
        end
        chk("d3_issue_cnt", log_q.size(), 9);
        chk("d3_core0_issues", c0, 6);
        chk("d3_jobs_lit", 32'(bus.jobs_done), 32'd9);
        step();

        run(0, 10);
        chk("d0_issue_cnt", log_q.size(), 0);
        chk("d0_end_off", end_off, 1);
        chk("d0_jobs_lit", 32'(bus.jobs_done), 32'd0);
        step();
        step();

        lat_tab    = '{2, 4, 3, 5};
        spur_done  = 1;
        spur_start = 1;
        run(4, 300);
        spur_done  = 0;
        spur_start = 0;
        bus.start_process = 1'b0;
        chk("spur_jobs_lit", 32'(bus.jobs_done), 32'd16);
        step();

        hold_start = 1;
        run(1, 50);
        hold_start = 0;
        run(2, 100);
        chk("held_restart_jobs", 32'(bus.jobs_done), 32'd4);
        step();

        lat_tab = '{1, 20, 20, 20};
        bus.dim = 8'd4;
        bus.start_process = 1'b1;
        step();
        bus.start_process = 1'b0;
        for (int n = 0; n < 20 && log_q.size() < 5; n++) step();
        chk("rst_pre_issues", log_q.size(), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_core_start", 32'(bus.core_start), 32'd0);
        chk("rst_core_row", bus.core_row, 32'd0);
        chk("rst_core_col", bus.core_col, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_end", 32'(bus.end_process), 32'd0);
        chk("rst_jobs", 32'(bus.jobs_done), 32'd0);
`ifdef SCHED_PERF_CNT_EN
        chk("rst_cycle_count", cycle_count, 32'd0);
`endif
        model_reset();
        bus.core_done = 4'b1111;
        step();
        step();
        rst_n = 1'b1;
        step();
        run(4, 300);
        chk("post_rst_first_core", log_q.size() > 0 ? log_q[0].core : -1, 0);
        chk("post_rst_first_row", log_q.size() > 0 ? log_q[0].row : -1, 0);
        chk("post_rst_first_col", log_q.size() > 0 ? log_q[0].col : -1, 0);
        step();

        lat_rand   = 1;
        spur_done  = 1;
        spur_start = 1;
        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(1, 6)), 500);
            bus.start_process = 1'b0;
            step();
        end
        lat_rand   = 0;
        spur_done  = 0;
        spur_start = 0;
        bus.start_process = 1'b0;
        step();

`ifdef SCHED_PERF_CNT_EN
        for (int i = 0; i < NC; i++) lat_tab[i] = 2;
        run(1, 20);
        chk("perf_end_off", end_off, 5);
        chk("perf_cycles_lit", cycle_count, 32'd5);
        step();
        step();
        step();
        chk("perf_hold_lit", cycle_count, 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
